ita_gelu_sched: RTL
===================

Name: ita_gelu_sched

Overview:
Time-multiplexed sequencer that streams N_IN-lane requantized activation vectors through N_GELU shared ita_gelu instances.
- Owns the GELU constant registers (one, b, c) and applies them only when the block is idle.
- Accepts one input vector, splits it into P = N_IN/N_GELU slices, issues one slice per cycle to the GELU lanes, and collects the results into an output buffer.
- Presents the full output vector on a valid/ready interface.
- Sits between the requantizer output and the activation write-back path.

Parameters:
N_IN, 16, lanes per input/output vector
N_GELU, 4, shared ita_gelu instances; N_IN mod N_GELU must be 0 (elaboration assertion)
P (localparam), N_IN/N_GELU, passes per vector; counter width max(1, clog2(P))

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
cfg_valid_i  in  1  constant-update request
cfg_ready_o  out  1  constant update accepted this cycle
cfg_one_i  in  gelu_const_t  new "one" constant
cfg_b_i  in  gelu_const_t  new "b" constant
cfg_c_i  in  gelu_const_t  new "c" constant
in_valid_i  in  1  input vector valid
in_ready_o  out  1  input vector accepted
in_data_i  in  N_IN x requant_t  input vector, element j = lane j
out_valid_o  out  1  output vector valid
out_ready_i  in  1  downstream ready
out_data_o  out  N_IN x gelu_out_t  GELU results, element j = GELU(in element j)
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i high at rising edge):
  - state=IDLE, pass counter=0, out_valid_o=0.
  - out_data_o buffer=0, input register=0, constant registers one/b/c=0.
  - Reset mid-COMPUTE or mid-DONE drops the vector; no output is produced for it.
- States:
  - IDLE: cfg_ready_o=1. in_ready_o = !cfg_valid_i.
    - cfg_valid_i=1: constants latched at the edge; stay IDLE.
    - Otherwise in_valid_i=1: latch in_data_i, pass counter:=0, go to COMPUTE.
    - Config has priority over data on the same cycle; the vector is accepted on the next cycle with the new constants.
  - COMPUTE: cfg_ready_o=0, in_ready_o=0.
    - Each cycle, GELU lane i receives input-register element k*N_GELU+i, where k = pass counter.
    - Combinational ita_gelu outputs are written into out buffer elements k*N_GELU+i at the edge.
    - k increments each cycle. When k = P-1 the write completes, state goes to DONE, and k wraps to 0.
  - DONE: out_valid_o=1; buffer and input register are frozen.
    - out_ready_i=1 goes to IDLE.
    - No accept in DONE: in_ready_o=0.
- Latency: input handshake at edge t gives out_valid_o=1 in the cycle following edge t+P, i.e. P+1 cycles. Minimum issue interval is P+2 cycles per vector.
- AXI-style hold:
  - out_data_o is stable while out_valid_o=1 and !out_ready_i.
  - out_valid_o never drops without a handshake.
- GELU constants feed all N_GELU instances from registers, never directly from cfg_*_i, so they are constant for a whole vector.
- Arithmetic:
  - Entirely inside ita_gelu, including width truncation of gelu_out_t.
  - The sequencer adds no rounding or saturation.
- cfg_valid_i outside IDLE is ignored (cfg_ready_o=0). The requester holds it until accepted.
- in_valid_i and in_data_i may change freely while in_ready_o=0.
- P=1: COMPUTE lasts exactly one cycle.

Test Plan:
1. Reset, then cfg one=2, b=-4, c=1. Input vector with lane0=2, lane1=-2, lane2=0, lane3=10, rest 0 → out lanes 14, 6, 0, 30, rest 0; out_valid_o rises exactly P+1=5 cycles after accept (N_IN=16, N_GELU=4).
2. Lane mapping: in lane j = j-8 (j=0..15), same constants → every out lane matches the golden model at index j. Confirms slice k=1..3 ordering with no lane swaps.
3. Backpressure: hold out_ready_i=0 for 10 cycles after out_valid_o → data stable and in_ready_o=0 throughout. Release → one handshake, IDLE next cycle, busy_o=0.
4. Simultaneous cfg_valid_i and in_valid_i in IDLE:
   - Cycle 0: only config taken, in_ready_o=0.
   - Cycle 1: vector taken.
   - Result uses the new constants (change one from 2 to 3: lane value 2 → 16).
5. cfg_valid_i pulsed during COMPUTE and DONE → cfg_ready_o=0; result unchanged; cfg accepted the first cycle back in IDLE.
6. Assert rst_i during COMPUTE pass 2 → next cycle IDLE, out_valid_o=0, out_data_o=0, constants=0. A subsequent vector with constants reloaded produces correct results.

Source files
------------

// File: rtl/ita_gelu_sched.sv
// Time-multiplexed GELU sequencer: one N_IN-lane vector is pushed through
// N_GELU shared ita_gelu lanes, N_GELU elements per cycle, then held for the consumer.

module ita_gelu #(
    parameter int IN_W    = 8,
    parameter int CONST_W = 16,
    parameter int OUT_W   = 26
) (
    input  logic [CONST_W-1:0] one_i,
    input  logic [CONST_W-1:0] b_i,
    input  logic [CONST_W-1:0] c_i,
    input  logic [IN_W-1:0]    data_i,
    output logic [OUT_W-1:0]   data_o
);
    localparam int D_W = CONST_W + 2;

    logic signed [IN_W:0]    x;
    logic signed [IN_W:0]    abs_x;
    logic signed [D_W-1:0]   abs_e;
    logic signed [D_W-1:0]   b_e;
    logic signed [D_W-1:0]   neg_b;
    logic signed [D_W-1:0]   clip;
    logic signed [D_W-1:0]   d;
    logic signed [OUT_W-1:0] l_pos;
    logic signed [OUT_W-1:0] l_sgn;
    logic signed [OUT_W-1:0] erf;
    logic signed [OUT_W-1:0] prod;

    // The clip compare needs full width; everything after it is a ring
    // operation, so computing it modulo 2^OUT_W gives the truncated result exactly.
    always_comb begin
        x     = {data_i[IN_W-1], data_i};
        abs_x = x[IN_W] ? -x : x;
        abs_e = D_W'(abs_x);
        b_e   = D_W'($signed(b_i));
        neg_b = -b_e;
        clip  = (abs_e < neg_b) ? abs_e : neg_b;
        d     = clip + b_e;
        l_pos = OUT_W'(d) * OUT_W'(d) + OUT_W'($signed(c_i));
        l_sgn = x[IN_W] ? -l_pos : l_pos;
        erf   = l_sgn + OUT_W'($signed(one_i));
        prod  = OUT_W'(x) * erf;
    end

    assign data_o = prod;
endmodule

module ita_gelu_sched #(
    parameter int N_IN    = 16,
    parameter int N_GELU  = 4,
    parameter int IN_W    = 8,
    parameter int CONST_W = 16,
    parameter int OUT_W   = 26
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       cfg_valid_i,
    output logic                       cfg_ready_o,
    input  logic [CONST_W-1:0]         cfg_one_i,
    input  logic [CONST_W-1:0]         cfg_b_i,
    input  logic [CONST_W-1:0]         cfg_c_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [N_IN-1:0][IN_W-1:0]  in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [N_IN-1:0][OUT_W-1:0] out_data_o,
    output logic                       busy_o
);
    localparam int P  = N_IN / N_GELU;
    localparam int CW = (P > 1) ? $clog2(P) : 1;

    generate
        if (N_IN % N_GELU != 0) begin : g_bad_split
            $error("N_IN must be a multiple of N_GELU");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [N_IN-1:0][IN_W-1:0]   in_q;
    logic [N_IN-1:0][OUT_W-1:0]  out_q;
    logic [CONST_W-1:0]          one_q, b_q, c_q;
    logic                        cfg_fire, in_fire, out_we;
    logic [N_GELU-1:0][IN_W-1:0]  lane_in;
    logic [N_GELU-1:0][OUT_W-1:0] lane_out;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Config wins over data in IDLE so a vector never straddles a constant change.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cfg_ready_o = 1'b0;
        in_ready_o  = 1'b0;
        cfg_fire    = 1'b0;
        in_fire     = 1'b0;
        out_we      = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready_o = 1'b1;
                in_ready_o  = !cfg_valid_i;
                cfg_fire    = cfg_valid_i;
                if (in_valid_i && !cfg_valid_i) begin
                    in_fire = 1'b1;
                    cnt_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                out_we = 1'b1;
                if (cnt_q == CW'(P - 1)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lane_in = '0;
        for (int j = 0; j < N_IN; j++) begin
            if (cnt_q == CW'(j / N_GELU)) lane_in[j % N_GELU] = in_q[j];
        end
    end

    ita_gelu #(
        .IN_W    (IN_W),
        .CONST_W (CONST_W),
        .OUT_W   (OUT_W)
    ) u_gelu [N_GELU-1:0] (
        .one_i  (one_q),
        .b_i    (b_q),
        .c_i    (c_q),
        .data_i (lane_in),
        .data_o (lane_out)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_q  <= '0;
            out_q <= '0;
            one_q <= '0;
            b_q   <= '0;
            c_q   <= '0;
        end else begin
            if (cfg_fire) begin
                one_q <= cfg_one_i;
                b_q   <= cfg_b_i;
                c_q   <= cfg_c_i;
            end
            if (in_fire) in_q <= in_data_i;
            for (int j = 0; j < N_IN; j++) begin
                if (out_we && cnt_q == CW'(j / N_GELU)) out_q[j] <= lane_out[j % N_GELU];
            end
        end
    end

    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign out_data_o  = out_q;
endmodule
